bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rstn.
REQ-002 Port: clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 Port: rstn  input  1  synchronous reset, active-low.
REQ-004 Port: en  input  1  count enable; when 0, step pulses are ignored.
REQ-005 Port: up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 Port: step  input  1  synchronous step request; each 0->1 transition advances the count once.
REQ-007 Port: load  input  1  synchronous load strobe.
REQ-008 Port: load_val  input  8  BCD load value; [7:4] = tens digit, [3:0] = ones digit.
REQ-009 Port: count  output  8  current BCD count, 00..99; [7:4] = tens, [3:0] = ones.
REQ-010 Port: tc  output  1  terminal count; 1 when (up=1 and count=99) or (up=0 and count=00).
REQ-011 Port: err  output  1  sticky invalid-load flag.
REQ-012 Parameter: none; width is fixed at 2 BCD digits.

Function
REQ-013 The block SHALL hold step_d, the value of step sampled at the previous posedge.
REQ-014 Define pulse = step & ~step_d; a step held high for N cycles SHALL produce exactly one advance.
REQ-015 The count SHALL be stored only in toggle flip-flops (8 bits); the block SHALL drive each flip-flop's t input with (current bit XOR target bit).
REQ-016 Priority at a posedge: rstn=0 first, then load=1, then (en=1 and pulse=1) advance, otherwise hold (all t=0).
REQ-017 Up advance: ones 0..8 -> ones+1; ones 9 -> ones=0 and the tens digit increments; 99 -> 00 (wrap).
REQ-018 Down advance: ones 1..9 -> ones-1; ones 0 -> ones=9 and the tens digit decrements; 00 -> 99 (wrap).
REQ-019 Latency: count SHALL show the new value immediately after the posedge at which pulse=1 is sampled (zero added cycles).
REQ-020 Load: each digit of load_val that is <=9 SHALL load as given, and each digit >9 SHALL load as 0.
REQ-021 A load containing any digit >9 SHALL set err to 1; a fully valid load SHALL clear err to 0; err SHALL otherwise hold its value.
REQ-022 A load and a pulse in the same cycle: the load SHALL win and the pulse SHALL be discarded (it is not deferred).
REQ-023 step_d SHALL update every cycle regardless of en or load, so a rising edge masked by load or en=0 is consumed.
REQ-024 tc SHALL be combinational from count and up, with no register.
REQ-025 Changing up between pulses SHALL take effect on the next pulse; tc SHALL follow up in the same cycle.
REQ-026 count SHALL never leave the BCD range 00..99 under any input sequence.

Reset
REQ-027 When rstn=0 at a posedge, count SHALL become 00, err SHALL become 0 and step_d SHALL become 0, overriding load and step.
REQ-028 After reset, tc SHALL be 0 if up=1 and 1 if up=0.
REQ-029 Reset asserted during a held step SHALL clear step_d to 0, so if step is still 1 at the first posedge after reset releases, one advance occurs.

Structure
REQ-030 Sub-module: T_FF (existing toggle flip-flop; ports clk, rstn, t, q), instantiated 8 times, one per count bit; the clk and rstn ports SHALL be shared.
REQ-031 Constants BCD_MAX_DIGIT=4'd9 and BCD_MIN_DIGIT=4'd0 SHALL reside in the shared lab package; this block SHALL define no other package items.
REQ-032 The next-value and toggle-vector logic SHALL be combinational in this module; the only non-T_FF register SHALL be step_d plus err.

Verification
REQ-033 Reset with up=1 -> count=00, err=0, tc=0; then en=1 and 12 single-cycle step pulses (step low between them) -> count=12.
REQ-034 load_val=8'h98 -> count=98; with up=1, 2 pulses -> 99 with tc=1, then 00 with tc=0.
REQ-035 count=00 with up=0 -> tc=1; 1 pulse -> count=99; set up=1 -> tc=1 in the same cycle.
REQ-036 step held high for 10 cycles with en=1 -> exactly one advance; with en=0 -> count unchanged.
REQ-037 load_val=8'h3C -> count=30 and err=1; then load_val=8'h45 -> count=45 and err=0; a load and a pulse in the same cycle -> load value only.
REQ-038 Reset mid-sequence at count=57 with step high -> count=00; after rstn rises with step still high -> count=01.

Source files
------------

// File: rtl/bcd_updown_counter_pkg.sv
// ============================================================================
// bcd_updown_counter_pkg : digit limits shared by the BCD counter block
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_updown_counter_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] BCD_MIN_DIGIT = 4'd0;

endpackage

`default_nettype wire

// File: rtl/bcd_updown_counter_if.sv
// ============================================================================
// bcd_updown_counter_if : control inputs and count outputs of the BCD counter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bcd_updown_counter_if;

    logic       en;
    logic       up;
    logic       step;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc;
    logic       err;

    modport master (
        output en, up, step, load, load_val,
        input  count, tc, err
    );

    modport slave (
        input  en, up, step, load, load_val,
        output count, tc, err
    );

endinterface

`default_nettype wire

// File: rtl/bcd_updown_counter_t_ff.sv
// ============================================================================
// T_FF : toggle flip-flop with synchronous active-low reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module T_FF (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic t,
    output logic      q
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_updown_counter.sv
// ============================================================================
// bcd_updown_counter : two-digit BCD up/down counter held in toggle flops
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rstn,
    bcd_updown_counter_if.slave bus
);

    logic [7:0] count;
    logic [7:0] target;
    logic [7:0] toggle;
    logic [7:0] adv_val;
    logic [7:0] load_fix;
    logic       load_bad;
    logic       pulse;
    logic       step_d;
    logic       err;

    logic [3:0] ones;
    logic [3:0] tens;

    assign ones  = count[3:0];
    assign tens  = count[7:4];
    assign pulse = bus.step & ~step_d;

    // Out-of-range digits are replaced by zero and flagged.
    always_comb begin
        load_fix = bus.load_val;
        load_bad = 1'b0;
        if (bus.load_val[3:0] > BCD_MAX_DIGIT) begin
            load_fix[3:0] = BCD_MIN_DIGIT;
            load_bad      = 1'b1;
        end
        if (bus.load_val[7:4] > BCD_MAX_DIGIT) begin
            load_fix[7:4] = BCD_MIN_DIGIT;
            load_bad      = 1'b1;
        end
    end

    always_comb begin
        adv_val = count;
        if (bus.up) begin
            if (ones >= BCD_MAX_DIGIT) begin
                adv_val[3:0] = BCD_MIN_DIGIT;
                adv_val[7:4] = (tens >= BCD_MAX_DIGIT) ? BCD_MIN_DIGIT : tens + 4'd1;
            end else begin
                adv_val[3:0] = ones + 4'd1;
            end
        end else begin
            if (ones == BCD_MIN_DIGIT || ones > BCD_MAX_DIGIT) begin
                adv_val[3:0] = BCD_MAX_DIGIT;
                adv_val[7:4] = (tens == BCD_MIN_DIGIT || tens > BCD_MAX_DIGIT)
                               ? BCD_MAX_DIGIT : tens - 4'd1;
            end else begin
                adv_val[3:0] = ones - 4'd1;
            end
        end
    end

    always_comb begin
        target = count;
        if (bus.load) begin
            target = load_fix;
        end else if (bus.en && pulse) begin
            target = adv_val;
        end
    end

    assign toggle = count ^ target;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_tff
            T_FF u_tff (
                .clk  (clk),
                .rstn (rstn),
                .t    (toggle[i]),
                .q    (count[i])
            );
        end
    endgenerate

    // step_d tracks step every cycle so masked rising edges are consumed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            step_d <= 1'b0;
            err    <= 1'b0;
        end else begin
            step_d <= bus.step;
            if (bus.load) begin
                err <= load_bad;
            end
        end
    end

    assign bus.count = count;
    assign bus.err   = err;
    assign bus.tc    = bus.up ? (count == {BCD_MAX_DIGIT, BCD_MAX_DIGIT})
                              : (count == {BCD_MIN_DIGIT, BCD_MIN_DIGIT});

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
// ============================================================================
// tb_bcd_updown_counter : directed scoreboard bench for bcd_updown_counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_updown_counter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    bcd_updown_counter_if bus ();

    bcd_updown_counter dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
        logic       err;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    task automatic push(input string tag, input logic [7:0] c, input logic t, input logic e);
        exp_t x;
        x.count = c;
        x.tc    = t;
        x.err   = e;
        exp_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        exp_t  x;
        string tag;
        x   = exp_q.pop_front();
        tag = tag_q.pop_front();
        checks++;
        assert (bus.count === x.count) else begin
            errors++;
            $error("FAIL %s count: observed %h expected %h", tag, bus.count, x.count);
        end
        checks++;
        assert (bus.tc === x.tc) else begin
            errors++;
            $error("FAIL %s tc: observed %b expected %b", tag, bus.tc, x.tc);
        end
        checks++;
        assert (bus.err === x.err) else begin
            errors++;
            $error("FAIL %s err: observed %b expected %b", tag, bus.err, x.err);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected post-edge state, clock once, then compare.
    task automatic cycle(input string tag, input logic [7:0] c, input logic t, input logic e);
        push(tag, c, t, e);
        tick();
        pop_check();
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.step     = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 8'h00;

        // Reset, count up by 12 single-cycle pulses.
        tick();
        cycle("reset", 8'h00, 1'b0, 1'b0);
        rstn   = 1'b1;
        bus.en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            bus.step = 1'b1;
            cycle("up_pulse", to_bcd(i), 1'b0, 1'b0);
            bus.step = 1'b0;
            cycle("up_idle", to_bcd(i), 1'b0, 1'b0);
        end

        // Load 98, count through 99 and wrap to 00.
        bus.load = 1'b1; bus.load_val = 8'h98;
        cycle("load98", 8'h98, 1'b0, 1'b0);
        bus.load = 1'b0;
        bus.step = 1'b1; cycle("to99", 8'h99, 1'b1, 1'b0);
        bus.step = 1'b0; cycle("hold99", 8'h99, 1'b1, 1'b0);
        bus.step = 1'b1; cycle("wrap00", 8'h00, 1'b0, 1'b0);
        bus.step = 1'b0; cycle("hold00", 8'h00, 1'b0, 1'b0);

        // Down direction: tc at 00, wrap to 99, tc follows up immediately.
        bus.up = 1'b0;
        push("tc_down00", 8'h00, 1'b1, 1'b0); #1; pop_check();
        bus.step = 1'b1; cycle("wrap99", 8'h99, 1'b0, 1'b0);
        bus.step = 1'b0; cycle("hold99d", 8'h99, 1'b0, 1'b0);
        bus.up = 1'b1;
        push("tc_follow_up", 8'h99, 1'b1, 1'b0); #1; pop_check();

        // Down borrow from tens.
        bus.up = 1'b0;
        bus.load = 1'b1; bus.load_val = 8'h40;
        cycle("load40", 8'h40, 1'b0, 1'b0);
        bus.load = 1'b0;
        bus.step = 1'b1; cycle("borrow39", 8'h39, 1'b0, 1'b0);
        bus.step = 1'b0; cycle("hold39", 8'h39, 1'b0, 1'b0);
        bus.up = 1'b1;

        // Held step gives one advance; with en=0 nothing moves.
        bus.load = 1'b1; bus.load_val = 8'h20;
        cycle("load20", 8'h20, 1'b0, 1'b0);
        bus.load = 1'b0;
        bus.step = 1'b1;
        cycle("held_first", 8'h21, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle("held_rest", 8'h21, 1'b0, 1'b0);
        bus.step = 1'b0; cycle("held_release", 8'h21, 1'b0, 1'b0);
        bus.en = 1'b0; bus.step = 1'b1;
        for (int i = 0; i < 10; i++) cycle("en0_held", 8'h21, 1'b0, 1'b0);
        bus.step = 1'b0; cycle("en0_release", 8'h21, 1'b0, 1'b0);
        bus.en = 1'b1;

        // Invalid load, sticky err, valid load clears, load beats pulse.
        bus.load = 1'b1; bus.load_val = 8'h3C;
        cycle("load3C", 8'h30, 1'b0, 1'b1);
        bus.load = 1'b0;
        bus.step = 1'b1; cycle("err_hold", 8'h31, 1'b0, 1'b1);
        bus.step = 1'b0; cycle("err_hold2", 8'h31, 1'b0, 1'b1);
        bus.load = 1'b1; bus.load_val = 8'hA5;
        cycle("loadA5", 8'h05, 1'b0, 1'b1);
        bus.load_val = 8'h45;
        cycle("load45", 8'h45, 1'b0, 1'b0);
        bus.load_val = 8'h10; bus.step = 1'b1;
        cycle("load_vs_pulse", 8'h10, 1'b0, 1'b0);
        bus.load = 1'b0;
        cycle("pulse_discarded", 8'h10, 1'b0, 1'b0);
        bus.step = 1'b0; cycle("after_discard", 8'h10, 1'b0, 1'b0);

        // Reset with step held; advance once reset releases.
        bus.load = 1'b1; bus.load_val = 8'h57;
        cycle("load57", 8'h57, 1'b0, 1'b0);
        bus.load = 1'b0; bus.step = 1'b1; rstn = 1'b0;
        cycle("rst_mid", 8'h00, 1'b0, 1'b0);
        cycle("rst_hold", 8'h00, 1'b0, 1'b0);
        rstn = 1'b1;
        cycle("rst_release", 8'h01, 1'b0, 1'b0);
        cycle("rst_release_hold", 8'h01, 1'b0, 1'b0);
        bus.step = 1'b0;
        bus.up   = 1'b0;
        rstn     = 1'b0;
        cycle("rst_up0_tc", 8'h00, 1'b1, 1'b0);
        rstn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
